// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and the transmitter.
//   uart_rx_state_e : receiver FSM states
//   uart_rx_dbg_t   : receiver internals gathered for checkers
//   OVERSAMPLE      : ticks per bit period
//   calc_div()      : clocks per oversampling tick, rounded to nearest
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } uart_rx_state_e;

  localparam int OVERSAMPLE = 16;

  // Per-bit tick counter values (ticks already seen in this bit) at which
  // the line is sampled. The vote happens on the tick where the counter is
  // VOTE_CNT, using the two stored samples plus the live line value, so
  // the three samples sit on ticks 7, 8 and 9 of the bit period.
  localparam logic [3:0] SAMPLE_A_CNT = 4'd6;
  localparam logic [3:0] SAMPLE_B_CNT = 4'd7;
  localparam logic [3:0] VOTE_CNT     = 4'd8;

  typedef struct packed {
    uart_rx_state_e state;
    logic [2:0]     bit_idx;
    logic [3:0]     tick_cnt;
    logic           fifo_full;
    logic           fifo_empty;
  } uart_rx_dbg_t;

  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with ready/valid on both sides.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready/in_data     : write side
//   out_valid/out_ready/out_data  : read side; out_data is the head entry
//   full, empty                   : occupancy flags
// Handshake: a transfer happens on a side in every cycle where its valid
// and ready are both high; valid never depends on ready of the same side.
// When full, in_ready follows out_ready so a write can share the cycle
// with a read and occupancy stays unchanged.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign out_valid = !empty;
  assign in_ready  = !full || out_ready;
  assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push   = in_valid && in_ready;
  assign do_pop    = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = in_data;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and a small output FIFO.
//   clk_sys, rst_sys : clock, synchronous active-high reset
//   rx_i             : asynchronous serial line, idles high
//   rx_data_o        : FIFO head byte
//   rx_valid_o       : FIFO not empty
//   rx_ready_i       : consumer takes the head byte when rx_valid_o is high
//   frame_err_o      : 1-cycle pulse, stop bit sampled low
//   overrun_o        : 1-cycle pulse, good byte dropped on a full FIFO
//   busy_o           : FSM not in IDLE
// Internal state is gathered in the dbg struct for bound checkers.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk_sys,
  input  logic       rst_sys,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);
  localparam int            DIV      = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [1:0]     sync_q, sync_d;
  logic           prev_q, prev_d;
  logic [DW-1:0]  div_cnt_q, div_cnt_d;
  uart_rx_state_e state_q, state_d;
  logic [3:0]     tick_cnt_q, tick_cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [1:0]     samp_q, samp_d;
  logic           frame_err_q, frame_err_d;
  logic           overrun_q, overrun_d;

  logic           rx_sync, tick, in_frame, vote, vote_now;
  logic           push_valid, push_ready;
  logic           fifo_full, fifo_empty;
  uart_rx_dbg_t   dbg;

  assign rx_sync  = sync_q[1];
  assign tick     = (div_cnt_q == DIV_LAST);
  assign in_frame = (state_q == START) || (state_q == DATA) || (state_q == STOP);
  assign vote     = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_sync) |
                    (samp_q[0] & rx_sync);
  assign vote_now = tick && (tick_cnt_q == VOTE_CNT);

  always_comb begin
    sync_d      = {sync_q[0], rx_i};
    prev_d      = rx_sync;
    div_cnt_d   = tick ? '0 : div_cnt_q + DW'(1);
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    samp_d      = samp_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    push_valid  = 1'b0;

    // The per-bit tick counter runs modulo 16 from the start edge, so the
    // vote after the start bit lines up with the data bit centres without
    // any realignment.
    if (in_frame && tick) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
      if (tick_cnt_q == SAMPLE_A_CNT || tick_cnt_q == SAMPLE_B_CNT) begin
        samp_d = {samp_q[0], rx_sync};
      end
    end

    case (state_q)
      IDLE: begin
        if (prev_q && !rx_sync) begin
          state_d    = START;
          div_cnt_d  = '0;
          tick_cnt_d = '0;
          bit_idx_d  = '0;
        end
      end
      START: begin
        if (vote_now) state_d = vote ? IDLE : DATA;
      end
      DATA: begin
        if (vote_now) begin
          shift_d = {vote, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (vote_now) begin
          if (vote) begin
            push_valid = 1'b1;
            overrun_d  = !push_ready;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        // Hold through a break until the line recovers.
        if (rx_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      sync_q      <= 2'b11;
      prev_q      <= 1'b1;
      div_cnt_q   <= '0;
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      samp_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      div_cnt_q   <= div_cnt_d;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      samp_q      <= samp_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_sys),
    .rst      (rst_sys),
    .in_valid (push_valid),
    .in_ready (push_ready),
    .in_data  (shift_q),
    .out_valid(rx_valid_o),
    .out_ready(rx_ready_i),
    .out_data (rx_data_o),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != IDLE);

  assign dbg = '{state: state_q, bit_idx: bit_idx_q, tick_cnt: tick_cnt_q,
                 fifo_full: fifo_full, fifo_empty: fifo_empty};

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames are driven on rx_i, expected bytes are
// pushed into exp_q by a FIFO-level reference model, and a monitor pops and
// compares whenever the DUT hands over a byte.
module tb_uart_rx;
  // Clock/baud chosen so a full run stays short: round(10e6/(104167*16)) = 6
  localparam int CLK_HZ   = 10_000_000;
  localparam int BAUD_R   = 104_167;
  localparam int DIV      = 6;
  localparam int BIT_CLKS = 16 * DIV;
  localparam int DEPTH    = 4;
  // Stop-bit vote: 16 start ticks + 8*16 data ticks + 9th tick of stop bit
  localparam int STOP_VOTE_TICK = 16 + 8 * 16 + 9;

  logic       clk = 1'b0;
  logic       rst_sys = 1'b1;
  logic       rx_i = 1'b1;
  logic       ready_ctl = 1'b0;
  logic       rnd_ready = 1'b0;
  logic       rand_mode = 1'b0;
  logic       rx_ready_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, frame_err_o, overrun_o, busy_o;

  assign rx_ready_i = rand_mode ? rnd_ready : ready_ctl;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         vcnt = 0;
  int         exp_fe = 0, exp_ov = 0, act_fe = 0, act_ov = 0;
  logic [7:0] exp_q[$];
  int         pop_cyc_q[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  uart_rx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD       (BAUD_R),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_sys    (clk),
    .rst_sys    (rst_sys),
    .rx_i       (rx_i),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .busy_o     (busy_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) rnd_ready <= 1'($urandom_range(0, 1));

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int bclk);
    rx_i = 1'b0;
    step(bclk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      step(bclk);
    end
    rx_i = stop_v;
    step(bclk);
    rx_i = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rx_i = 1'b1;
    step(n * BIT_CLKS);
  endtask

  // Reference model: a good frame yields a byte unless the FIFO already
  // holds DEPTH undelivered bytes and no read coincides with the write.
  task automatic model_push(input logic [7:0] b, input logic pop_same);
    if (exp_q.size() < DEPTH || pop_same) exp_q.push_back(b);
    else exp_ov++;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_events(input string name);
    check({name, "_frame_err_cnt"}, act_fe, exp_fe);
    check({name, "_overrun_cnt"}, act_ov, exp_ov);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    cyc++;
    if (rst_sys) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && rx_valid_o) check("hold_stable", rx_data_o, prev_data);
      if (rx_valid_o) vcnt++;
      if (rx_valid_o && rx_ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h want none", rx_data_o);
        end else begin
          check("rx_byte", rx_data_o, exp_q.pop_front());
        end
        pop_cyc_q.push_back(cyc);
      end
      if (frame_err_o) act_fe++;
      if (overrun_o) act_ov++;
      if (frame_err_o && overrun_o) check("err_exclusive", 2'b11, 2'b01);
      prev_hold = rx_valid_o && !rx_ready_i;
      prev_data = rx_data_o;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int v0, n, bclk, kind;
    logic [7:0] b;

    step(5);
    rst_sys = 1'b0;
    @(negedge clk);
    check("rst_valid", rx_valid_o, 0);
    check("rst_data", rx_data_o, 8'h00);
    check("rst_busy", busy_o, 0);
    check("rst_frame_err", frame_err_o, 0);
    check("rst_overrun", overrun_o, 0);
    step(1);

    // Back-to-back 0x55, 0xA5
    ready_ctl = 1'b1;
    idle_bits(1);
    v0 = vcnt;
    model_push(8'h55, 1'b0);
    send_frame(8'h55, 1'b1, BIT_CLKS);
    model_push(8'hA5, 1'b0);
    send_frame(8'hA5, 1'b1, BIT_CLKS);
    idle_bits(2);
    wait_drain("b2b_drain");
    check("b2b_valid_cycles", vcnt - v0, 2);
    check_events("b2b");

    // 3-tick low glitch
    v0 = vcnt;
    rx_i = 1'b0;
    step(3 * DIV);
    rx_i = 1'b1;
    idle_bits(2);
    check("glitch_busy", busy_o, 0);
    check("glitch_no_valid", vcnt - v0, 0);
    check_events("glitch");

    // Framing error, then a good frame
    exp_fe++;
    send_frame(8'h3C, 1'b0, BIT_CLKS);
    idle_bits(2);
    check("ferr_busy", busy_o, 0);
    check("ferr_no_valid", rx_valid_o, 0);
    check_events("ferr");
    model_push(8'h7E, 1'b0);
    send_frame(8'h7E, 1'b1, BIT_CLKS);
    idle_bits(2);
    wait_drain("ferr_drain");
    check_events("after_ferr");

    // Fill the FIFO with no consumer, fifth byte overruns
    ready_ctl = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      model_push(8'(i), 1'b0);
      send_frame(8'(i), 1'b1, BIT_CLKS);
      idle_bits(1);
    end
    check("full_valid", rx_valid_o, 1);
    check("full_head", rx_data_o, 8'h01);
    check_events("overrun");

    // Sixth byte completes in the same cycle as a single read
    model_push(8'h06, 1'b1);
    fork
      send_frame(8'h06, 1'b1, BIT_CLKS);
      begin
        n = 0;
        while (!busy_o && n < 2 * BIT_CLKS) begin
          @(negedge clk);
          n++;
        end
        check("busy_rise", busy_o, 1);
        repeat (STOP_VOTE_TICK * DIV - 1) @(posedge clk);
        #1 ready_ctl = 1'b1;
        @(posedge clk);
        #1 ready_ctl = 1'b0;
      end
    join
    idle_bits(1);
    check_events("push_pop");
    pop_cyc_q.delete();
    ready_ctl = 1'b1;
    wait_drain("stream_drain");
    check("stream_count", pop_cyc_q.size(), 4);
    for (int i = 1; i < pop_cyc_q.size(); i++)
      check("stream_consecutive", pop_cyc_q[i] - pop_cyc_q[i-1], 1);

    // Reset during bit 4 of 0xF0 with a byte still queued
    ready_ctl = 1'b0;
    model_push(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b1, BIT_CLKS);
    idle_bits(1);
    check("pre_rst_valid", rx_valid_o, 1);
    fork
      send_frame(8'hF0, 1'b1, BIT_CLKS);
      begin
        step(5 * BIT_CLKS + BIT_CLKS / 2);
        rst_sys = 1'b1;
        exp_q.delete();
        step(1);
        rst_sys = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", rx_valid_o, 0);
        check("mid_rst_data", rx_data_o, 8'h00);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_frame_err", frame_err_o, 0);
        check("mid_rst_overrun", overrun_o, 0);
      end
    join
    idle_bits(1);
    check("post_rst_no_valid", rx_valid_o, 0);
    ready_ctl = 1'b1;
    model_push(8'h81, 1'b0);
    send_frame(8'h81, 1'b1, BIT_CLKS);
    idle_bits(2);
    wait_drain("post_rst_drain");
    check_events("post_rst");

    // Random frames, glitches and framing errors with +-3% bit length
    rand_mode = 1'b1;
    for (int k = 0; k < 16; k++) begin
      kind = $urandom_range(0, 9);
      bclk = $urandom_range(BIT_CLKS - 3, BIT_CLKS + 3);
      b    = 8'($urandom_range(0, 255));
      if (kind == 0) begin
        rx_i = 1'b0;
        step($urandom_range(1, 5 * DIV));
        rx_i = 1'b1;
        idle_bits(1);
      end else if (kind == 1) begin
        exp_fe++;
        send_frame(b, 1'b0, bclk);
        idle_bits(1);
      end else begin
        model_push(b, 1'b0);
        send_frame(b, 1'b1, bclk);
        step($urandom_range(0, 2) * bclk);
      end
    end
    idle_bits(2);
    wait_drain("rand_drain");
    check_events("rand");
    rand_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
